// File: rtl/sel_debounce.sv
// Debounces a raw button and toggles the counter's direction select on every accepted press.
// Define SEL_DEBOUNCE_SYNC_EN to put a 2-flop synchronizer in front of the FSM.
module sel_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5,
    parameter logic        SEL_RESET       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic sel_o,
    output logic stable_o,
    output logic press_o
);

    // state     | meaning
    // IDLE      | debounced level low, button released
    // WAIT_HIGH | button seen high, counting consecutive high samples
    // PRESSED   | debounced level high, button held
    // WAIT_LOW  | button seen low, counting consecutive low samples
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic btn_s;

`ifdef SEL_DEBOUNCE_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_i;
            sync_q2 <= sync_q1;
        end
    end

    assign btn_s = sync_q2;
`else
    assign btn_s = btn_i;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= SEL_RESET;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        stable_d = stable_q;
        press_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // this edge is the DEBOUNCE_CYCLES-th consecutive high sample
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    stable_d = 1'b1;
                    press_d  = 1'b1;
                    sel_d    = ~sel_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    stable_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign sel_o    = sel_q;
    assign stable_o = stable_q;
    assign press_o  = press_q;

endmodule

// File: tb/tb_sel_debounce.sv
// Bench for sel_debounce: directed vector table, latency checks and random bursts against a run-length model.
module tb_sel_debounce;

    localparam int N = 4;
`ifdef SEL_DEBOUNCE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic btn_i;
    logic sel_o, stable_o, press_o;

    always #5 clk = ~clk;

    sel_debounce #(.DEBOUNCE_CYCLES(N), .CNT_W(5), .SEL_RESET(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_i    (btn_i),
        .sel_o    (sel_o),
        .stable_o (stable_o),
        .press_o  (press_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference: count consecutive samples that disagree with the accepted level;
    // N of them in a row flips the level, and a rising flip is a press.
    logic m_sel, m_stable, m_press;
    int   m_run;
    logic m_pipe [$];

    task automatic model_step(input logic b, input logic r);
        logic bs;
        if (!r) begin
            m_sel = 1'b1; m_stable = 1'b0; m_press = 1'b0; m_run = 0;
            m_pipe.delete();
            for (int i = 0; i < SYNC_LAT; i++) m_pipe.push_back(1'b0);
        end else begin
            m_pipe.push_back(b);
            bs = m_pipe.pop_front();
            m_press = 1'b0;
            if (bs != m_stable) m_run++;
            else m_run = 0;
            if (m_run == N) begin
                m_stable = bs;
                m_run = 0;
                if (bs) begin
                    m_press = 1'b1;
                    m_sel = ~m_sel;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic tick(input logic b, input logic r);
        btn_i = b;
        rst_n = r;
        @(posedge clk);
        model_step(b, r);
        #1;
        check("model_sel", sel_o, m_sel);
        check("model_stable", stable_o, m_stable);
        check("model_press", press_o, m_press);
    endtask

    typedef struct {
        logic btn;
        logic rst;
        logic sel;
        logic stable;
        logic press;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic b, input logic r, input logic s, input logic st,
                       input logic p, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{b, r, s, st, p});
    endtask

    initial begin
        int lat;
        bit seen;
        logic lvl;
        int len;
        logic r;

        btn_i = 1'b0;
        rst_n = 1'b0;

        // reset with toggling button
        add(1,0, 1,0,0, 1); add(0,0, 1,0,0, 1); add(1,0, 1,0,0, 1);
        add(0,1, 1,0,0, 3);
        // clean press and release
        add(1,1, 1,0,0, 3); add(1,1, 0,1,1, 1); add(1,1, 0,1,0, 2);
        add(0,1, 0,1,0, 3); add(0,1, 0,0,0, 3);
        // bounce 1,1,1,0,1,1,0,1,1,1,1
        add(1,1, 0,0,0, 3); add(0,1, 0,0,0, 1); add(1,1, 0,0,0, 2);
        add(0,1, 0,0,0, 1); add(1,1, 0,0,0, 3); add(1,1, 1,1,1, 1);
        add(1,1, 1,1,0, 1); add(0,1, 1,1,0, 3); add(0,1, 1,0,0, 2);
        // two presses, release glitch 0,0,0,1 during the first
        add(1,1, 1,0,0, 3); add(1,1, 0,1,1, 1);
        add(0,1, 0,1,0, 3); add(1,1, 0,1,0, 2);
        add(0,1, 0,1,0, 3); add(0,1, 0,0,0, 1);
        add(1,1, 0,0,0, 3); add(1,1, 1,1,1, 1); add(1,1, 1,1,0, 1);
        add(0,1, 1,1,0, 3); add(0,1, 1,0,0, 1);
        // reset mid-count, button held through reset release
        add(1,1, 1,0,0, 2); add(1,0, 1,0,0, 1);
        add(1,1, 1,0,0, 3); add(1,1, 0,1,1, 1); add(1,1, 0,1,0, 1);
        add(0,1, 0,1,0, 3); add(0,1, 0,0,0, 1);

        foreach (vecs[i]) begin
            tick(vecs[i].btn, vecs[i].rst);
`ifndef SEL_DEBOUNCE_SYNC_EN
            check($sformatf("vec%0d_sel", i), sel_o, vecs[i].sel);
            check($sformatf("vec%0d_stable", i), stable_o, vecs[i].stable);
            check($sformatf("vec%0d_press", i), press_o, vecs[i].press);
`endif
        end

        // accept latency from reset release with button held
        tick(0, 0); tick(0, 0);
        lat = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1, 1);
            lat++;
            if (press_o) seen = 1;
        end
        check("press_seen", seen, 1'b1);
        tests++;
        if (lat != N + SYNC_LAT) begin
            fails++;
            $display("FAIL press_latency: got %0d cycles expected %0d", lat, N + SYNC_LAT);
        end
        check("latency_sel", sel_o, 1'b0);
        tick(1, 1);
        check("press_one_cycle", press_o, 1'b0);

        // random bursts with occasional reset
        for (int i = 0; i < 600; i++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            r = ($urandom_range(0, 40) != 0);
            for (int j = 0; j < len; j++) tick(lvl, (j == 0) ? r : 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sel_debounce.md
Name: sel_debounce

Overview:
Cleans a raw push-button or switch input and produces the direction-select level for the 4-bit up/down counter stage (`sel_i`). It sits directly upstream of that counter and runs on the same clock. Each debounced press toggles the select level. A one-cycle press pulse and the debounced level are also exported for status logic.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive samples of a new input level needed to accept it; legal range 2 to 2^CNT_W-1.
- CNT_W, 5, width of the stability counter.
- SEL_RESET, 1'b1, value of `sel_o` in reset.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- btn_i  input  1  raw button, active-high, may bounce.
- sel_o  output  1  select level to the counter's `sel_i`; toggles once per accepted press.
- stable_o  output  1  debounced button level.
- press_o  output  1  one-cycle pulse on an accepted press (0→1 of `stable_o`).

Behaviour:
- One clock, `clk`. Reset is synchronous and active-low on `rst_n`, sampled on the rising edge of `clk`.
- Reset values:
  - `sel_o` = SEL_RESET; `stable_o` = 0; `press_o` = 0.
  - FSM = IDLE; `cnt` = 0.
- `btn_s` is the sampled button: `btn_i` directly, or the synchronizer output (see Optional Feature).
- All outputs are registered. No combinational path from `btn_i` to any output.
- FSM states (encoding is free): IDLE (stable low), WAIT_HIGH, PRESSED (stable high), WAIT_LOW.
- IDLE:
  - `btn_s`=1 → WAIT_HIGH, `cnt`=1.
  - Otherwise stay, `cnt`=0.
- WAIT_HIGH:
  - `btn_s`=0 → IDLE, `cnt`=0 (bounce rejected, no output change).
  - `btn_s`=1 and `cnt`==DEBOUNCE_CYCLES-1 → PRESSED, `cnt`=0. On that same edge: `stable_o`←1, `press_o`←1, `sel_o`←~`sel_o`.
  - `btn_s`=1 otherwise → `cnt`++.
- PRESSED:
  - `btn_s`=0 → WAIT_LOW, `cnt`=1.
  - Otherwise stay.
- WAIT_LOW:
  - `btn_s`=1 → PRESSED, `cnt`=0.
  - `btn_s`=0 and `cnt`==DEBOUNCE_CYCLES-1 → IDLE, `cnt`=0, `stable_o`←0. No pulse, no toggle.
  - Otherwise `cnt`++.
- `press_o` is high for exactly one cycle per accepted press and is cleared on the next edge.
- Latency: outputs update on the edge where `btn_s` has been sampled at the new level for DEBOUNCE_CYCLES consecutive edges, that edge included.
- Any glitch shorter than DEBOUNCE_CYCLES samples is ignored, in either direction.
- `cnt` never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-count or mid-press:
  - Reset returns the block to IDLE and restores `sel_o` to SEL_RESET.
  - A button still held when `rst_n` deasserts is accepted as a new press after DEBOUNCE_CYCLES samples.

Optional Feature:
- Macro: `SEL_DEBOUNCE_SYNC_EN`.
- Defined:
  - `btn_i` passes through a 2-flop synchronizer before the FSM. Both flops reset to 0 synchronously.
  - Accept latency grows by 2 cycles.
  - The synchronizer flops are the only added state.
- Undefined: `btn_s` = `btn_i`, sampled directly by the FSM (caller guarantees `btn_i` is synchronous to `clk`).

Test Plan (DEBOUNCE_CYCLES=4, SEL_RESET=1, macro undefined unless stated):
1. Reset: `rst_n`=0 for 3 cycles with `btn_i` toggling → `sel_o`=1, `stable_o`=0, `press_o`=0 throughout.
2. Clean press: `btn_i`=1 held from cycle 10 → on the 4th sampling edge `stable_o`=1, `press_o`=1 for exactly 1 cycle, `sel_o`=0; release for 4 cycles → `stable_o`=0, `sel_o` stays 0.
3. Bounce: `btn_i` pattern 1,1,1,0,1,1,0,1,1,1,1 → exactly one press accepted, at the 4th of the final four 1s; `sel_o` toggles once.
4. Two full presses separated by a 4-cycle release → `sel_o` goes 1→0→1, two `press_o` pulses; release glitch 0,0,0,1 during PRESSED → no second pulse.
5. Reset mid-count: `btn_i`=1 for 2 cycles, then `rst_n`=0 for 1 cycle, then `rst_n`=1 with button held → press accepted 4 cycles after reset release, `sel_o`=0.
6. `SEL_DEBOUNCE_SYNC_EN` defined, repeat scenario 2 → `press_o` occurs exactly 2 cycles later than in scenario 2.
